// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point multiplier arbiter: FSM encoding,
// a constant clog2 helper and saturation bounds by width and signedness.
// Purely declarative; no logic, no latency, no flow control.
package fxp_pkg;

  // Operation sequencing: arbitrate, multiply, saturate, hold response
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_SAT  = 2'd2,
    ST_RSP  = 2'd3
  } fsm_state_t;

  // Ceiling log2 with a floor of 1 so a 1-bit id field always exists
  function automatic int fxp_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Largest representable value of a w-bit field (signed: 0111..., unsigned: 111...)
  function automatic longint sat_max(input int w, input logic sgn);
    return sgn ? ((longint'(1) << (w - 1)) - 1) : ((longint'(1) << w) - 1);
  endfunction

  // Smallest representable value of a w-bit field (signed: 1000..., unsigned: 0)
  function automatic longint sat_min(input int w, input logic sgn);
    return sgn ? -(longint'(1) << (w - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/fxp_mul_core.sv
// Fixed-point multiply then floor-truncate and saturate into the output format.
// Two registered stages: product on mul_en, result/flags on sat_en.
// No handshake of its own; the caller sequences the enables and holds inputs.
module fxp_mul_core
  import fxp_pkg::*;
#(
  parameter int A_I   = 3,
  parameter int A_F   = 2,
  parameter int B_I   = 4,
  parameter int B_F   = 2,
  parameter int OUT_I = 5,
  parameter int OUT_F = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mul_en,
  input  logic                   sat_en,
  input  logic [A_I+A_F-1:0]     a,
  input  logic [B_I+B_F-1:0]     b,
  input  logic                   sign,
  output logic [OUT_I+OUT_F-1:0] data,
  output logic                   ovf,
  output logic                   unf
);

  localparam int A_W   = A_I + A_F;
  localparam int B_W   = B_I + B_F;
  localparam int P_W   = A_W + B_W;
  localparam int PI    = A_I + B_I;
  localparam int PF    = A_F + B_F;
  localparam int OUT_W = OUT_I + OUT_F;

  // Align the product's binary point to the output's: shift left when the
  // output has more fraction bits, arithmetic shift right (floor) otherwise.
  localparam int SH_L = (OUT_F >= PF) ? (OUT_F - PF) : 0;
  localparam int SH_R = (OUT_F <  PF) ? (PF - OUT_F) : 0;

  // Working width covers the widest integer and fraction parts plus a sign
  // and a guard bit, so bound comparisons never wrap.
  localparam int WW = ((PI > OUT_I) ? PI : OUT_I) + ((PF > OUT_F) ? PF : OUT_F) + 2;

  localparam logic signed [WW-1:0] U_MAX = WW'(sat_max(OUT_W, 1'b0));
  localparam logic signed [WW-1:0] U_MIN = WW'(sat_min(OUT_W, 1'b0));
  localparam logic signed [WW-1:0] S_MAX = WW'(sat_max(OUT_W, 1'b1));
  localparam logic signed [WW-1:0] S_MIN = WW'(sat_min(OUT_W, 1'b1));

  // Product bits that fall below the output LSB; all zero when nothing is dropped
  localparam logic [P_W-1:0] DROP_MASK = P_W'((longint'(1) << SH_R) - 1);

  logic [P_W-1:0]          a_ext;
  logic [P_W-1:0]          b_ext;
  logic [P_W-1:0]          prod_d;
  logic [P_W-1:0]          prod_q;
  logic signed [WW-1:0]    p_ext;
  logic signed [WW-1:0]    scaled;
  logic signed [WW-1:0]    hi;
  logic signed [WW-1:0]    lo;
  logic [OUT_W-1:0]        data_d;
  logic                    ovf_d;
  logic                    unf_d;

  // Extend both operands to product width; the low P_W bits of the product
  // are then exact for both two's-complement and unsigned operands.
  always_comb begin
    a_ext  = sign ? {{(P_W-A_W){a[A_W-1]}}, a} : {{(P_W-A_W){1'b0}}, a};
    b_ext  = sign ? {{(P_W-B_W){b[B_W-1]}}, b} : {{(P_W-B_W){1'b0}}, b};
    prod_d = a_ext * b_ext;
  end

  // Product register, loaded in the multiply stage
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (mul_en) begin
      prod_q <= prod_d;
    end
  end

  // Rescale to the output binary point, then clamp to the output range
  always_comb begin
    p_ext  = sign ? {{(WW-P_W){prod_q[P_W-1]}}, prod_q} : {{(WW-P_W){1'b0}}, prod_q};
    scaled = (p_ext <<< SH_L) >>> SH_R;
    hi     = sign ? S_MAX : U_MAX;
    lo     = sign ? S_MIN : U_MIN;
    unf_d  = |(prod_q & DROP_MASK);
    ovf_d  = 1'b0;
    data_d = scaled[OUT_W-1:0];
    if (scaled > hi) begin
      ovf_d  = 1'b1;
      data_d = hi[OUT_W-1:0];
    end else if (scaled < lo) begin
      ovf_d  = 1'b1;
      data_d = lo[OUT_W-1:0];
    end
  end

  // Result register, loaded in the saturate stage and held until reloaded
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (sat_en) begin
      data <= data_d;
      ovf  <= ovf_d;
      unf  <= unf_d;
    end
  end

endmodule

// File: rtl/fxp_mul_arbiter.sv
// Round-robin shares one fixed-point multiplier among NREQ valid/ready requesters.
// Accept at edge T, rsp_valid high after edge T+2; one op in flight, issue every 4+ cycles.
// req_ready only in IDLE; result held while rsp_ready is low, no accept during the hold.
module fxp_mul_arbiter
  import fxp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int A_I   = 3,
  parameter int A_F   = 2,
  parameter int B_I   = 4,
  parameter int B_F   = 2,
  parameter int OUT_I = 5,
  parameter int OUT_F = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ*(A_I+A_F)-1:0]     req_a,
  input  logic [NREQ*(B_I+B_F)-1:0]     req_b,
  input  logic [NREQ-1:0]               req_sign,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [fxp_clog2(NREQ)-1:0]    rsp_id,
  output logic [OUT_I+OUT_F-1:0]        rsp_data,
  output logic                          rsp_ovf,
  output logic                          rsp_unf
);

  localparam int ID_W = fxp_clog2(NREQ);
  localparam int A_W  = A_I + A_F;
  localparam int B_W  = B_I + B_F;

  fsm_state_t       state_q;
  fsm_state_t       state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_next;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic [ID_W:0]    rr_sum;
  logic [ID_W-1:0]  rr_idx;
  logic             accept;
  logic             mul_en;
  logic             sat_en;
  logic [A_W-1:0]   a_sel;
  logic [B_W-1:0]   b_sel;
  logic             s_sel;
  logic [A_W-1:0]   a_q;
  logic [B_W-1:0]   b_q;
  logic             sign_q;
  logic [ID_W-1:0]  id_q;

  // First valid requester at or after the pointer, wrapping past NREQ-1
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (rr_sum >= (ID_W+1)'(NREQ)) rr_sum = rr_sum - (ID_W+1)'(NREQ);
      rr_idx = rr_sum[ID_W-1:0];
      if (!win_found && req_valid[rr_idx]) begin
        win_found = 1'b1;
        win_id    = rr_idx;
      end
    end
  end

  // Grant only from IDLE and never while reset is asserted
  always_comb begin
    accept    = (state_q == ST_IDLE) && !rst && win_found;
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
    ptr_next  = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + ID_W'(1);
  end

  // Steer the winner's operand slices toward the capture registers
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    s_sel = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_id == ID_W'(k)) begin
        a_sel = req_a[k*A_W +: A_W];
        b_sel = req_b[k*B_W +: B_W];
        s_sel = req_sign[k];
      end
    end
  end

  // Operand capture and pointer advance on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      sign_q <= 1'b0;
      id_q   <= '0;
    end else if (accept) begin
      ptr_q  <= ptr_next;
      a_q    <= a_sel;
      b_q    <= b_sel;
      sign_q <= s_sel;
      id_q   <= win_id;
    end
  end

  // State register; reset aborts any in-flight op without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath stage enables
  always_comb begin
    state_d = state_q;
    mul_en  = 1'b0;
    sat_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_MUL;
      ST_MUL: begin
        mul_en  = 1'b1;
        state_d = ST_SAT;
      end
      ST_SAT: begin
        sat_en  = 1'b1;
        state_d = ST_RSP;
      end
      ST_RSP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response id travels alongside the result register load
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id <= '0;
    end else if (sat_en) begin
      rsp_id <= id_q;
    end
  end

  assign rsp_valid = (state_q == ST_RSP);

  fxp_mul_core #(
    .A_I   (A_I),
    .A_F   (A_F),
    .B_I   (B_I),
    .B_F   (B_F),
    .OUT_I (OUT_I),
    .OUT_F (OUT_F)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .mul_en (mul_en),
    .sat_en (sat_en),
    .a      (a_q),
    .b      (b_q),
    .sign   (sign_q),
    .data   (rsp_data),
    .ovf    (rsp_ovf),
    .unf    (rsp_unf)
  );

endmodule

// File: tb/tb_fxp_mul_arbiter.sv
// Scoreboard bench: grants and results predicted from arithmetic and a round-robin model.
// Stimulus drives at posedge+1; the monitor samples on the falling edge.
// rsp_ready is randomly withheld to exercise result holding.
`timescale 1ns/1ps
module tb_fxp_mul_arbiter;

  localparam int NREQ  = 4;
  localparam int A_I   = 3;
  localparam int A_F   = 2;
  localparam int B_I   = 4;
  localparam int B_F   = 2;
  localparam int OUT_I = 5;
  localparam int OUT_F = 3;
  localparam int A_W   = A_I + A_F;
  localparam int B_W   = B_I + B_F;
  localparam int OUT_W = OUT_I + OUT_F;
  localparam int PF    = A_F + B_F;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*A_W-1:0]   req_a;
  logic [NREQ*B_W-1:0]   req_b;
  logic [NREQ-1:0]       req_sign;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [OUT_W-1:0]      rsp_data;
  logic                  rsp_ovf;
  logic                  rsp_unf;

  fxp_mul_arbiter #(
    .NREQ(NREQ), .A_I(A_I), .A_F(A_F), .B_I(B_I), .B_F(B_F), .OUT_I(OUT_I), .OUT_F(OUT_F)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sign(req_sign),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int data;
    int ovf;
    int unf;
    int gcyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   glog_id[$];
  int   glog_cyc[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rr_ptr = 0;
  int   last_gcyc = -100;
  int   acc_id = -1;
  bit   ovr_en = 0;
  int   ovr_d, ovr_o, ovr_u;
  logic prev_vld = 0, prev_rdy = 0, prev_o = 0, prev_u = 0;
  logic [OUT_W-1:0] prev_data = '0;
  logic [ID_W-1:0]  prev_id = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Real-valued semantics: product of the two operands, floored to the output
  // LSB, then clamped to the representable output range.
  function automatic void model(input int a, input int b, input bit s,
                                output int d, output int o, output int u);
    int ai, bi, p, dv, t, hi, lo;
    ai = (s && a >= (1 << (A_W - 1))) ? a - (1 << A_W) : a;
    bi = (s && b >= (1 << (B_W - 1))) ? b - (1 << B_W) : b;
    p  = ai * bi;
    u  = 0;
    if (OUT_F >= PF) begin
      t = p * (1 << (OUT_F - PF));
    end else begin
      dv = 1 << (PF - OUT_F);
      t  = p / dv;
      if (p % dv != 0) begin
        u = 1;
        if (p < 0) t = t - 1;
      end
    end
    hi = s ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
    lo = s ? -(1 << (OUT_W - 1)) : 0;
    o  = 0;
    if (t > hi) begin t = hi; o = 1; end
    else if (t < lo) begin t = lo; o = 1; end
    d = t & ((1 << OUT_W) - 1);
  endfunction

  // Monitor: grant prediction, scoreboard pop/compare, hold and latency checks
  always @(negedge clk) begin : monitor
    int w, a, b, s, d, o, u;
    if (rst) begin
      if (req_valid != 0) chk("ready_in_reset", req_ready, 0);
      prev_vld = 0;
      prev_rdy = 0;
    end else begin
      if (sb.size() == 0 && req_valid != 0) begin
        w = -1;
        for (int i = 0; i < NREQ; i++)
          if (w < 0 && req_valid[(rr_ptr + i) % NREQ]) w = (rr_ptr + i) % NREQ;
        chk("grant", req_ready, 1 << w);
        if (req_ready != 0) begin
          chk("issue_gap_ge4", (cyc - last_gcyc >= 4), 1);
          a = int'(req_a[w*A_W +: A_W]);
          b = int'(req_b[w*B_W +: B_W]);
          s = int'(req_sign[w]);
          if (ovr_en) begin d = ovr_d; o = ovr_o; u = ovr_u; end
          else model(a, b, s[0], d, o, u);
          sb.push_back('{id: w, data: d, ovf: o, unf: u, gcyc: cyc});
          glog_id.push_back(w);
          glog_cyc.push_back(cyc);
          last_gcyc = cyc;
          rr_ptr    = (w + 1) % NREQ;
          acc_id    = w;
        end
      end else begin
        chk("no_grant", req_ready, 0);
      end

      if (prev_vld && !prev_rdy) begin
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, prev_data);
        chk("hold_id", rsp_id, prev_id);
        chk("hold_flags", {rsp_ovf, rsp_unf}, {prev_o, prev_u});
      end

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 0);
        end else begin
          e = sb[0];
          if (!prev_vld) chk("latency", cyc - e.gcyc, 3);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_ovf", rsp_ovf, e.ovf);
          chk("rsp_unf", rsp_unf, e.unf);
          if (rsp_ready) void'(sb.pop_front());
        end
      end
      prev_vld  = rsp_valid;
      prev_rdy  = rsp_ready;
      prev_data = rsp_data;
      prev_id   = rsp_id;
      prev_o    = rsp_ovf;
      prev_u    = rsp_unf;
    end
  end

  task automatic set_ops(input int k, input int a, input int b, input bit s);
    req_a[k*A_W +: A_W] = A_W'(a);
    req_b[k*B_W +: B_W] = B_W'(b);
    req_sign[k]         = s;
  endtask

  function automatic int pick(input int w);
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r == 1) return (1 << w) - 1;
    if (r == 2) return 1 << (w - 1);
    return $urandom_range(0, (1 << w) - 1);
  endfunction

  task automatic drive_rand(input int k);
    set_ops(k, pick(A_W), pick(B_W), 1'($urandom_range(0, 1)));
    acc_id       = -1;
    req_valid[k] = 1'b1;
  endtask

  // Wait for requester k to be accepted, then withdraw its request
  task automatic wait_acc(input int k);
    for (int t = 0; t < 60 && acc_id < 0; t++) @(posedge clk);
    #1;
    chk("accept_id", acc_id, k);
    req_valid[k] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 80 && sb.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic issue(input int k, input int a, input int b, input bit s,
                       input int ed, input int eo, input int eu);
    ovr_en = 1; ovr_d = ed; ovr_o = eo; ovr_u = eu;
    set_ops(k, a, b, s);
    acc_id       = -1;
    req_valid[k] = 1'b1;
    wait_acc(k);
    ovr_en = 0;
    drain();
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    sb.delete();
    rr_ptr    = 0;
    last_gcyc = -100;
    repeat (ncyc) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_sign  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_rsp_flags", {rsp_ovf, rsp_unf}, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;

    // Directed arithmetic corners
    issue(0, 'b01110, 'b001001, 0, 'h3F, 0, 0);
    issue(1, 'b00001, 'b000001, 0, 'h00, 0, 1);
    issue(2, 'b11111, 'b111111, 0, 'hFF, 1, 1);
    issue(3, 'b11100, 'b001000, 1, 'hF0, 0, 0);
    issue(0, 'b10000, 'b100000, 1, 'h7F, 1, 0);

    // Fairness: everyone requesting continuously from reset
    do_reset(2);
    glog_id.delete();
    glog_cyc.delete();
    for (int k = 0; k < NREQ; k++) drive_rand(k);
    for (int t = 0; t < 60 && glog_id.size() < 5; t++) @(posedge clk);
    #1;
    req_valid = '0;
    chk("fair_count", glog_id.size(), 5);
    for (int i = 0; i < 5 && i < glog_id.size(); i++) begin
      chk("fair_order", glog_id[i], i % NREQ);
      if (i > 0) chk("fair_spacing", glog_cyc[i] - glog_cyc[i-1], 4);
    end
    drain();

    // Response held under backpressure while another requester waits
    rsp_ready = 1'b0;
    drive_rand(1);
    wait_acc(1);
    drive_rand(2);
    for (int t = 0; t < 20 && !rsp_valid; t++) @(negedge clk);
    chk("hold_seen", rsp_valid, 1);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_acc(2);
    drain();

    // Reset while the multiply stage is busy
    drive_rand(3);
    wait_acc(3);
    do_reset(1);
    @(negedge clk);
    chk("rst_mid_vld", rsp_valid, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < NREQ; k++) drive_rand(k);
    for (int t = 0; t < 20 && acc_id < 0; t++) @(posedge clk);
    #1;
    chk("post_rst_grant", acc_id, 0);
    req_valid = '0;
    drain();

    // Random traffic with random consumer backpressure
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      if (acc_id >= 0) begin
        req_valid[acc_id] = 1'b0;
        acc_id = -1;
      end
      for (int k = 0; k < NREQ; k++)
        if (!req_valid[k] && $urandom_range(0, 3) == 0) drive_rand(k);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
